// File: rtl/bist_response_checker_if.sv
// Bus bundle for bist_response_checker: compare stimulus in, compare
// results and session status out.
// Optional feature: define BIST_CHK_MASK_EN to add the cmp_mask bit-exclusion input.
interface bist_response_checker_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter int CNT_W  = 8
);
  logic              start;
  logic              cmp_valid;
  logic              last;
  logic [DATA_W-1:0] data_t;
  logic [DATA_W-1:0] ramout;
  logic [ADDR_W-1:0] addr;
`ifdef BIST_CHK_MASK_EN
  logic [DATA_W-1:0] cmp_mask;
`endif
  logic              gt;
  logic              eq;
  logic              lt;
  logic              res_valid;
  logic              fail;
  logic [CNT_W-1:0]  fail_cnt;
  logic [ADDR_W-1:0] first_fail_addr;
  logic [DATA_W-1:0] first_fail_data;
  logic              busy;
  logic              done;
  logic              pass;

  modport master (
    output start, cmp_valid, last, data_t, ramout, addr,
`ifdef BIST_CHK_MASK_EN
    output cmp_mask,
`endif
    input  gt, eq, lt, res_valid, fail, fail_cnt, first_fail_addr,
           first_fail_data, busy, done, pass
  );

  modport slave (
    input  start, cmp_valid, last, data_t, ramout, addr,
`ifdef BIST_CHK_MASK_EN
    input  cmp_mask,
`endif
    output gt, eq, lt, res_valid, fail, fail_cnt, first_fail_addr,
           first_fail_data, busy, done, pass
  );
endinterface

// File: rtl/bist_response_checker.sv
// BIST response checker: compares expected data against RAM read data
// over a session (IDLE -> RUN -> DONE), reporting a registered unsigned
// gt/eq/lt result, a sticky fail flag, a saturating mismatch count and the
// address/data of the first mismatch.
// Optional feature: define BIST_CHK_MASK_EN to enable per-bit compare masking.
module bist_response_checker #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter int CNT_W  = 8
) (
  input logic                    clk,
  input logic                    rst,
  bist_response_checker_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            r_state;
  logic              r_gt;
  logic              r_eq;
  logic              r_lt;
  logic              r_res_valid;
  logic              r_fail;
  logic [CNT_W-1:0]  r_fail_cnt;
  logic [ADDR_W-1:0] r_first_fail_addr;
  logic [DATA_W-1:0] r_first_fail_data;
  logic              r_busy;
  logic              r_done;
  logic              r_pass;

  logic [DATA_W-1:0] w_exp;
  logic [DATA_W-1:0] w_act;
  logic              w_gt;
  logic              w_eq;
  logic              w_lt;
  logic              w_cnt_max;

  // Operand selection: masked bits are forced to zero on both sides so they never differ.
  always_comb begin
`ifdef BIST_CHK_MASK_EN
    w_exp = bus.data_t & ~bus.cmp_mask;
    w_act = bus.ramout & ~bus.cmp_mask;
`else
    w_exp = bus.data_t;
    w_act = bus.ramout;
`endif
  end

  assign w_gt      = (w_exp >  w_act);
  assign w_eq      = (w_exp == w_act);
  assign w_lt      = (w_exp <  w_act);
  assign w_cnt_max = (r_fail_cnt == {CNT_W{1'b1}});

  // Session FSM with all result and status outputs registered alongside the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state           <= S_IDLE;
      r_gt              <= 1'b0;
      r_eq              <= 1'b0;
      r_lt              <= 1'b0;
      r_res_valid       <= 1'b0;
      r_fail            <= 1'b0;
      r_fail_cnt        <= {CNT_W{1'b0}};
      r_first_fail_addr <= {ADDR_W{1'b0}};
      r_first_fail_data <= {DATA_W{1'b0}};
      r_busy            <= 1'b0;
      r_done            <= 1'b0;
      r_pass            <= 1'b0;
    end else begin
      // res_valid is a one-cycle strobe; only an accepted compare raises it
      r_res_valid <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            r_state           <= S_RUN;
            r_fail            <= 1'b0;
            r_fail_cnt        <= {CNT_W{1'b0}};
            r_first_fail_addr <= {ADDR_W{1'b0}};
            r_first_fail_data <= {DATA_W{1'b0}};
            r_busy            <= 1'b1;
            r_done            <= 1'b0;
            r_pass            <= 1'b0;
          end else begin
            r_state <= r_state;
          end
        end
        S_RUN: begin
          if (bus.start) begin
            // restart wins over a coincident compare, which is dropped
            r_fail            <= 1'b0;
            r_fail_cnt        <= {CNT_W{1'b0}};
            r_first_fail_addr <= {ADDR_W{1'b0}};
            r_first_fail_data <= {DATA_W{1'b0}};
          end else if (bus.cmp_valid) begin
            r_gt        <= w_gt;
            r_eq        <= w_eq;
            r_lt        <= w_lt;
            r_res_valid <= 1'b1;
            if (!w_eq) begin
              r_fail <= 1'b1;
              if (!w_cnt_max) begin
                r_fail_cnt <= r_fail_cnt + CNT_W'(1'b1);
              end else begin
                r_fail_cnt <= r_fail_cnt;
              end
              if (!r_fail) begin
                r_first_fail_addr <= bus.addr;
                r_first_fail_data <= bus.ramout;
              end else begin
                r_first_fail_addr <= r_first_fail_addr;
              end
            end else begin
              r_fail <= r_fail;
            end
            if (bus.last) begin
              // pass must include the verdict of this final compare
              r_state <= S_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_pass  <= ~(r_fail | ~w_eq);
            end else begin
              r_state <= S_RUN;
            end
          end else begin
            r_state <= S_RUN;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_pass  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.gt              = r_gt;
  assign bus.eq              = r_eq;
  assign bus.lt              = r_lt;
  assign bus.res_valid       = r_res_valid;
  assign bus.fail            = r_fail;
  assign bus.fail_cnt        = r_fail_cnt;
  assign bus.first_fail_addr = r_first_fail_addr;
  assign bus.first_fail_data = r_first_fail_data;
  assign bus.busy            = r_busy;
  assign bus.done            = r_done;
  assign bus.pass            = r_pass;

endmodule

// File: tb/tb_bist_response_checker.sv
// Self-checking bench for bist_response_checker: table-driven vectors with
// a queue of expected results, plus hand-written reset, masking and
// counter-saturation sequences (the latter on a CNT_W=2 instance).
module tb_bist_response_checker;

  logic clk;
  logic rst;

  int checks;
  int failures;

  typedef struct {
    logic       rs, st, cv, lst;
    logic [7:0] d, r, a, m;
    logic       rv, gt, eq, lt, fl;
    logic [7:0] cnt, ffa, ffd;
    logic       bsy, dn, ps;
  } vec_t;

  vec_t exp_q[$];
  int   sat_q[$];
  vec_t tbl[14];

  bist_response_checker_if #(.DATA_W(8), .ADDR_W(8), .CNT_W(8)) bus ();
  bist_response_checker_if #(.DATA_W(8), .ADDR_W(8), .CNT_W(2)) bus2 ();

  bist_response_checker #(.DATA_W(8), .ADDR_W(8), .CNT_W(8)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  bist_response_checker #(.DATA_W(8), .ADDR_W(8), .CNT_W(2)) dut_sat (
    .clk(clk),
    .rst(rst),
    .bus(bus2)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(
    input logic rs, st, cv, lst,
    input logic [7:0] d, r, a, m,
    input logic rv, gt, eq, lt, fl,
    input logic [7:0] cnt, ffa, ffd,
    input logic bsy, dn, ps);
    vec_t v;
    v.rs = rs; v.st = st; v.cv = cv; v.lst = lst;
    v.d = d; v.r = r; v.a = a; v.m = m;
    v.rv = rv; v.gt = gt; v.eq = eq; v.lt = lt; v.fl = fl;
    v.cnt = cnt; v.ffa = ffa; v.ffd = ffd;
    v.bsy = bsy; v.dn = dn; v.ps = ps;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Drive one vector, queue its expectation, then compare one cycle later.
  task automatic apply(input vec_t v, input string nm);
    vec_t e;
    rst           = v.rs;
    bus.start     = v.st;
    bus.cmp_valid = v.cv;
    bus.last      = v.lst;
    bus.data_t    = v.d;
    bus.ramout    = v.r;
    bus.addr      = v.a;
`ifdef BIST_CHK_MASK_EN
    bus.cmp_mask  = v.m;
`endif
    exp_q.push_back(v);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    chk({nm, ".res_valid"}, 32'(bus.res_valid), 32'(e.rv));
    chk({nm, ".gt"},        32'(bus.gt),        32'(e.gt));
    chk({nm, ".eq"},        32'(bus.eq),        32'(e.eq));
    chk({nm, ".lt"},        32'(bus.lt),        32'(e.lt));
    chk({nm, ".fail"},      32'(bus.fail),      32'(e.fl));
    chk({nm, ".fail_cnt"},  32'(bus.fail_cnt),  32'(e.cnt));
    chk({nm, ".ffa"},       32'(bus.first_fail_addr), 32'(e.ffa));
    chk({nm, ".ffd"},       32'(bus.first_fail_data), 32'(e.ffd));
    chk({nm, ".busy"},      32'(bus.busy),      32'(e.bsy));
    chk({nm, ".done"},      32'(bus.done),      32'(e.dn));
    chk({nm, ".pass"},      32'(bus.pass),      32'(e.ps));
  endtask

  initial begin
    clk = 1'b0;
    rst = 1'b1;
    checks = 0;
    failures = 0;
    bus.start = 1'b0; bus.cmp_valid = 1'b0; bus.last = 1'b0;
    bus.data_t = 8'h00; bus.ramout = 8'h00; bus.addr = 8'h00;
`ifdef BIST_CHK_MASK_EN
    bus.cmp_mask = 8'h00;
    bus2.cmp_mask = 8'h00;
`endif
    bus2.start = 1'b0; bus2.cmp_valid = 1'b0; bus2.last = 1'b0;
    bus2.data_t = 8'h00; bus2.ramout = 8'h00; bus2.addr = 8'h00;

    //              rs st cv ls d      r      a      m      rv gt eq lt fl cnt    ffa    ffd    bsy dn ps
    tbl[0]  = mk(0, 1, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 0, 0, 0, 8'd0, 8'h00, 8'h00, 1, 0, 0);
    tbl[1]  = mk(0, 0, 1, 1, 8'h10, 8'h10, 8'h00, 8'h00, 1, 0, 1, 0, 0, 8'd0, 8'h00, 8'h00, 0, 1, 1);
    tbl[2]  = mk(0, 0, 1, 1, 8'h20, 8'h10, 8'h01, 8'h00, 0, 0, 1, 0, 0, 8'd0, 8'h00, 8'h00, 0, 1, 1);
    tbl[3]  = mk(0, 1, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 1, 0, 0, 8'd0, 8'h00, 8'h00, 1, 0, 0);
    tbl[4]  = mk(0, 0, 1, 0, 8'h20, 8'h10, 8'h03, 8'h00, 1, 1, 0, 0, 1, 8'd1, 8'h03, 8'h10, 1, 0, 0);
    tbl[5]  = mk(0, 0, 1, 0, 8'h20, 8'h30, 8'h04, 8'h00, 1, 0, 0, 1, 1, 8'd2, 8'h03, 8'h10, 1, 0, 0);
    tbl[6]  = mk(0, 0, 0, 0, 8'h20, 8'h30, 8'h04, 8'h00, 0, 0, 0, 1, 1, 8'd2, 8'h03, 8'h10, 1, 0, 0);
    tbl[7]  = mk(0, 0, 0, 1, 8'h20, 8'h30, 8'h04, 8'h00, 0, 0, 0, 1, 1, 8'd2, 8'h03, 8'h10, 1, 0, 0);
    tbl[8]  = mk(0, 0, 1, 0, 8'h55, 8'h55, 8'h05, 8'h00, 1, 0, 1, 0, 1, 8'd2, 8'h03, 8'h10, 1, 0, 0);
    tbl[9]  = mk(0, 1, 1, 0, 8'h00, 8'h01, 8'h06, 8'h00, 0, 0, 1, 0, 0, 8'd0, 8'h00, 8'h00, 1, 0, 0);
    tbl[10] = mk(0, 0, 1, 1, 8'hFF, 8'h00, 8'h07, 8'h00, 1, 1, 0, 0, 1, 8'd1, 8'h07, 8'h00, 0, 1, 0);
    tbl[11] = mk(0, 1, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 1, 0, 0, 0, 8'd0, 8'h00, 8'h00, 1, 0, 0);
    tbl[12] = mk(0, 0, 1, 0, 8'h00, 8'hFF, 8'h09, 8'h00, 1, 0, 0, 1, 1, 8'd1, 8'h09, 8'hFF, 1, 0, 0);
    tbl[13] = mk(0, 0, 1, 0, 8'h01, 8'h02, 8'h0A, 8'h00, 1, 0, 0, 1, 1, 8'd2, 8'h09, 8'hFF, 1, 0, 0);

    // reset state
    apply(mk(1, 0, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 0, 0, 0, 8'd0, 8'h00, 8'h00, 0, 0, 0), "reset0");
    apply(mk(1, 1, 1, 1, 8'h01, 8'h02, 8'h03, 8'h00, 0, 0, 0, 0, 0, 8'd0, 8'h00, 8'h00, 0, 0, 0), "reset_prio");

    for (int i = 0; i < 14; i++) begin
      apply(tbl[i], $sformatf("vec%0d", i));
    end

    // reset mid-RUN with a compare pending, then a compare while IDLE
    apply(mk(1, 0, 1, 0, 8'h12, 8'h34, 8'h0B, 8'h00, 0, 0, 0, 0, 0, 8'd0, 8'h00, 8'h00, 0, 0, 0), "rst_mid_run");
    apply(mk(0, 0, 1, 1, 8'h12, 8'h34, 8'h0B, 8'h00, 0, 0, 0, 0, 0, 8'd0, 8'h00, 8'h00, 0, 0, 0), "idle_cmp");

`ifdef BIST_CHK_MASK_EN
    apply(mk(0, 1, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 0, 0, 0, 8'd0, 8'h00, 8'h00, 1, 0, 0), "mask_start");
    apply(mk(0, 0, 1, 0, 8'hA5, 8'hA3, 8'h0C, 8'h0F, 1, 0, 1, 0, 0, 8'd0, 8'h00, 8'h00, 1, 0, 0), "mask_0f");
    apply(mk(0, 0, 1, 1, 8'hA5, 8'hA3, 8'h0D, 8'h00, 1, 1, 0, 0, 1, 8'd1, 8'h0D, 8'hA3, 0, 1, 0), "mask_00");
`endif

    // saturation on the CNT_W=2 instance
    bus2.start = 1'b1;
    @(posedge clk);
    #1;
    bus2.start = 1'b0;
    chk("sat.busy", 32'(bus2.busy), 32'd1);
    for (int i = 1; i <= 5; i++) begin
      bus2.cmp_valid = 1'b1;
      bus2.data_t    = 8'(i);
      bus2.ramout    = 8'hC0;
      bus2.addr      = 8'(i);
      sat_q.push_back((i > 3) ? 3 : i);
      @(posedge clk);
      #1;
      chk($sformatf("sat.cnt%0d", i), 32'(bus2.fail_cnt), 32'(sat_q.pop_front()));
      chk($sformatf("sat.lt%0d", i), 32'(bus2.lt), 32'd1);
    end
    bus2.cmp_valid = 1'b0;
    chk("sat.ffa", 32'(bus2.first_fail_addr), 32'd1);
    chk("sat.fail", 32'(bus2.fail), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bist_response_checker.md
BIST_RESPONSE_CHECKER -- requirements
Module: bist_response_checker

Interface
REQ-001 SHALL have parameter DATA_W, default 8, compared data width.
REQ-002 SHALL have parameter ADDR_W, default 8, address width of captured fail location.
REQ-003 SHALL have parameter CNT_W, default 8, fail-counter width.
REQ-004 SHALL use one clock; reset is synchronous and active-high.
REQ-005 SHALL have port clk  input  1  rising-edge clock.
REQ-006 SHALL have port rst  input  1  synchronous active-high reset.
REQ-007 SHALL have port start  input  1  one-cycle pulse, begin/restart a check session.
REQ-008 SHALL have port cmp_valid  input  1  data_t/ramout/addr valid this cycle.
REQ-009 SHALL have port last  input  1  qualifies final compare of session (used only with cmp_valid).
REQ-010 SHALL have port data_t  input  DATA_W  expected data.
REQ-011 SHALL have port ramout  input  DATA_W  RAM read data.
REQ-012 SHALL have port addr  input  ADDR_W  address of current compare.
REQ-013 SHALL have ports gt, eq, lt  output  1 each  registered unsigned compare result of data_t vs ramout.
REQ-014 SHALL have port res_valid  output  1  gt/eq/lt valid.
REQ-015 SHALL have port fail  output  1  sticky mismatch flag for session.
REQ-016 SHALL have port fail_cnt  output  CNT_W  saturating mismatch count.
REQ-017 SHALL have ports first_fail_addr  output  ADDR_W and first_fail_data  output  DATA_W  address and ramout of first mismatch.
REQ-018 SHALL have ports busy, done, pass  output  1 each  session status.

Function
REQ-019 SHALL implement FSM IDLE, RUN, DONE; busy=1 only in RUN, done=1 only in DONE.
REQ-020 IDLE/DONE + start -> RUN, clearing fail, fail_cnt, first_fail_addr, first_fail_data, res_valid same edge.
REQ-021 RUN + start SHALL restart: clear as REQ-020, stay RUN, ignore cmp_valid that cycle.
REQ-022 RUN + cmp_valid: gt=(data_t>ramout), eq=(data_t==ramout), lt=(data_t<ramout), unsigned, registered, res_valid=1 next cycle (latency 1); exactly one of gt/eq/lt high when res_valid=1.
REQ-023 res_valid SHALL be 0 in cycles following no accepted compare; gt/eq/lt hold last value.
REQ-024 Mismatch (eq=0) SHALL set fail, increment fail_cnt saturating at 2^CNT_W-1 (no wrap).
REQ-025 first_fail_addr/data SHALL capture only on first mismatch of session, then hold.
REQ-026 RUN + cmp_valid + last -> DONE next edge, that compare fully accounted; last without cmp_valid ignored.
REQ-027 DONE: pass = ~fail; hold all results until start or rst; pass=0 outside DONE.
REQ-028 cmp_valid outside RUN SHALL be ignored (no result, no count change).

Reset
REQ-029 rst SHALL take priority over start and cmp_valid, mid-session included.
REQ-030 On rst: state IDLE; gt=0, eq=0, lt=0, res_valid=0, fail=0, fail_cnt=0, first_fail_addr=0, first_fail_data=0, busy=0, done=0, pass=0.

Configuration
REQ-031 Macro BIST_CHK_MASK_EN SHALL, when defined, add input cmp_mask [DATA_W]; bit=1 excludes that bit: compares use (data_t & ~cmp_mask) vs (ramout & ~cmp_mask).
REQ-032 Without BIST_CHK_MASK_EN, no cmp_mask port exists and all DATA_W bits are compared.

Verification
REQ-033 rst, start, cmp_valid data_t=8'h10 ramout=8'h10 last=1 -> next cycle eq=1 res_valid=1; then done=1, pass=1, fail_cnt=0.
REQ-034 RUN, compares (8'h20,8'h10) addr 3, (8'h20,8'h30) addr 4 -> gt then lt; fail=1, fail_cnt=2, first_fail_addr=3, first_fail_data=8'h10.
REQ-035 CNT_W=2, 5 mismatches -> fail_cnt saturates at 3.
REQ-036 rst asserted mid-RUN with cmp_valid=1 -> all outputs zero next cycle, state IDLE; start mid-RUN after mismatch -> fail=0, fail_cnt=0.
REQ-037 cmp_valid=1 in IDLE and DONE -> res_valid stays 0, counters unchanged.
REQ-038 With BIST_CHK_MASK_EN, cmp_mask=8'h0F, data_t=8'hA5 ramout=8'hA3 -> eq=1, fail=0; cmp_mask=8'h00 -> gt=1, fail=1.
